// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
package ifu_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // request out to imem at fetch_pc
    ST_WAIT = 2'd1,  // request accepted, waiting for the response
    ST_HOLD = 2'd2   // instruction captured, offered to ID
  } ifu_state_e;

  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/ifu_if.sv
// Fetch-side bundle: redirect in, imem request/response, IF->ID handoff.
// master = the fetch unit, slave = its environment (BJU, imem, ID).
interface ifu_if #(
  parameter int XLEN = 64
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_inst;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch: owns fetch_pc, keeps one imem request in flight,
// presents {pc, inst} to ID, and squashes wrong-path fetches on redirect.
module ifu
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic   clk,
  input  logic   rst_n,
  ifu_if.master  bus
);

  ifu_state_e      state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_inst;
  logic            kill;     // in-flight response belongs to a squashed path
  logic            req_acc;
  logic            id_acc;

  // A redirect withdraws the request for that cycle so a stale address is
  // never issued; rst_n gating keeps the request low while held in reset.
  assign bus.imem_req_valid = rst_n & (state == ST_REQ) & ~bus.redirect_valid;
  assign bus.imem_req_addr  = fetch_pc;
  // Masking with redirect prevents a wrong-path handshake with ID.
  assign bus.if_valid       = (state == ST_HOLD) & ~bus.redirect_valid;
  assign bus.if_pc          = hold_pc;
  assign bus.if_inst        = hold_inst;

  assign req_acc = bus.imem_req_valid & bus.imem_req_ready;
  assign id_acc  = bus.if_valid & bus.if_ready;

  // Fetch FSM with fetch_pc, kill flag and hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_REQ;
      fetch_pc  <= RESET_PC;
      kill      <= 1'b0;
      hold_pc   <= '0;
      hold_inst <= '0;
    end else begin
      // Redirect has priority over any sequential pc update below.
      if (bus.redirect_valid) fetch_pc <= bus.redirect_pc;

      case (state)
        ST_REQ: begin
          if (req_acc) begin
            state <= ST_WAIT;
            // Request going out alongside a redirect is on the wrong path.
            kill  <= bus.redirect_valid;
          end
        end
        ST_WAIT: begin
          if (bus.redirect_valid) begin
            if (bus.imem_rsp_valid) begin
              // Stale response arrives with the redirect: drop it right now.
              kill  <= 1'b0;
              state <= ST_REQ;
            end else begin
              kill  <= 1'b1;
            end
          end else if (bus.imem_rsp_valid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= ST_REQ;
            end else begin
              hold_pc   <= fetch_pc;
              hold_inst <= bus.imem_rsp_data;
              state     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.redirect_valid) begin
            hold_inst <= INST_NOP;
            state     <= ST_REQ;
          end else if (id_acc) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            state    <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed per-cycle vector table, reset-in-WAIT sequence,
// then random redirect/backpressure traffic against a program-order model.
module tb_ifu;
  localparam logic [63:0] A   = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_if #(.XLEN(64)) bus ();
  ifu #(.XLEN(64), .RESET_PC(A)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rv;   logic [63:0] rpc;
    logic        rdy;  logic        rspv; logic [31:0] rspd;
    logic        ird;
    logic        qv;   logic [63:0] qa;
    logic        iv;   logic [63:0] ipc;  logic [31:0] iinst;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rv, input logic [63:0] rpc, input logic rdy, input logic rspv,
                     input logic [31:0] rspd, input logic ird, input logic qv, input logic [63:0] qa,
                     input logic iv, input logic [63:0] ipc, input logic [31:0] iinst);
    vec_t v;
    v = '{rv, rpc, rdy, rspv, rspd, ird, qv, qa, iv, ipc, iinst};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rv, input logic [63:0] rpc, input logic rdy, input logic rspv,
                       input logic [31:0] rspd, input logic ird);
    bus.redirect_valid = rv;  bus.redirect_pc    = rpc;
    bus.imem_req_ready = rdy; bus.imem_rsp_valid = rspv;
    bus.imem_rsp_data  = rspd; bus.if_ready      = ird;
  endtask

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] memf(input logic [63:0] a);
    return (a[31:0] * 32'h0000_9e37) ^ 32'h0000_0013;
  endfunction

  logic [63:0] exp_pc, mem_addr, prev_qa, hi;
  bit          mem_busy, prev_pend;
  int          mem_cnt, idle, n_hs;

  initial begin
    drive(0, '0, 0, 0, '0, 0);
    hi = 64'hFFFF_FFFF_FFFF_FFFC;

    // Held in reset: all outputs quiet.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_if_valid",  bus.if_valid, 0);
    chk("rst_if_pc",     bus.if_pc, 0);
    chk("rst_if_inst",   bus.if_inst, 0);
    #2 rst_n = 1'b1;

    // rv rpc rdy rspv rspd ird | qv qa iv ipc iinst
    add(0, 0, 1, 0, 0, 0,                    1, A,        0, 0, 0);
    add(0, 0, 0, 1, 32'h0000_0093, 0,        0, A,        0, 0, 0);
    add(0, 0, 0, 0, 0, 1,                    0, A,        1, A, 32'h0000_0093);
    add(0, 0, 1, 0, 0, 0,                    1, A+4,      0, A, 32'h0000_0093);
    add(0, 0, 0, 1, 32'h0010_0113, 0,        0, A+4,      0, A, 32'h0000_0093);
    add(0, 0, 0, 0, 0, 1,                    0, A+4,      1, A+4, 32'h0010_0113);
    add(0, 0, 1, 0, 0, 0,                    1, A+8,      0, A+4, 32'h0010_0113);
    add(0, 0, 0, 1, 32'h0020_0193, 0,        0, A+8,      0, A+4, 32'h0010_0113);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 0, 0,                  0, A+8,      1, A+8, 32'h0020_0193);
    add(0, 0, 0, 0, 0, 1,                    0, A+8,      1, A+8, 32'h0020_0193);
    add(0, 0, 0, 0, 0, 0,                    1, A+12,     0, A+8, 32'h0020_0193);
    add(0, 0, 1, 0, 0, 0,                    1, A+12,     0, A+8, 32'h0020_0193);
    add(1, A+'h100, 0, 0, 0, 0,              0, A+12,     0, A+8, 32'h0020_0193);
    add(0, 0, 0, 1, 32'hdead_beef, 0,        0, A+'h100,  0, A+8, 32'h0020_0193);
    add(0, 0, 1, 0, 0, 0,                    1, A+'h100,  0, A+8, 32'h0020_0193);
    add(0, 0, 0, 1, 32'h0040_0213, 0,        0, A+'h100,  0, A+8, 32'h0020_0193);
    add(1, A+'h200, 0, 0, 0, 1,              0, A+'h100,  0, A+'h100, 32'h0040_0213);
    add(0, 0, 0, 0, 0, 0,                    1, A+'h200,  0, A+'h100, NOP);
    add(1, A+'h300, 1, 0, 0, 0,              0, A+'h200,  0, A+'h100, NOP);
    add(0, 0, 1, 0, 0, 0,                    1, A+'h300,  0, A+'h100, NOP);
    add(1, A+'h400, 0, 1, 32'h0bad_f00d, 0,  0, A+'h300,  0, A+'h100, NOP);
    add(0, 0, 1, 0, 0, 0,                    1, A+'h400,  0, A+'h100, NOP);
    add(0, 0, 0, 1, 32'h0060_0313, 0,        0, A+'h400,  0, A+'h100, NOP);
    add(0, 0, 0, 0, 0, 1,                    0, A+'h400,  1, A+'h400, 32'h0060_0313);
    add(0, 0, 1, 0, 0, 0,                    1, A+'h404,  0, A+'h400, 32'h0060_0313);
    add(1, A+'h500, 0, 0, 0, 0,              0, A+'h404,  0, A+'h400, 32'h0060_0313);
    add(1, A+'h600, 0, 0, 0, 0,              0, A+'h500,  0, A+'h400, 32'h0060_0313);
    add(0, 0, 0, 1, 32'hcafe_f00d, 0,        0, A+'h600,  0, A+'h400, 32'h0060_0313);
    add(0, 0, 1, 0, 0, 0,                    1, A+'h600,  0, A+'h400, 32'h0060_0313);
    add(0, 0, 0, 1, 32'h0080_0413, 0,        0, A+'h600,  0, A+'h400, 32'h0060_0313);
    add(0, 0, 0, 0, 0, 1,                    0, A+'h600,  1, A+'h600, 32'h0080_0413);
    add(1, hi, 0, 0, 0, 0,                   0, A+'h604,  0, A+'h600, 32'h0080_0413);
    add(0, 0, 1, 0, 0, 0,                    1, hi,       0, A+'h600, 32'h0080_0413);
    add(0, 0, 0, 1, 32'h0090_0493, 0,        0, hi,       0, A+'h600, 32'h0080_0413);
    add(0, 0, 0, 0, 0, 1,                    0, hi,       1, hi, 32'h0090_0493);
    add(1, A+'h702, 0, 0, 0, 0,              0, 0,        0, hi, 32'h0090_0493);
    add(0, 0, 0, 0, 0, 0,                    1, A+'h702,  0, hi, 32'h0090_0493);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].rspv, vecs[i].rspd, vecs[i].ird);
      @(negedge clk);
      chk($sformatf("v%0d_req_valid", i), bus.imem_req_valid, vecs[i].qv);
      chk($sformatf("v%0d_req_addr", i),  bus.imem_req_addr,  vecs[i].qa);
      chk($sformatf("v%0d_if_valid", i),  bus.if_valid,       vecs[i].iv);
      chk($sformatf("v%0d_if_pc", i),     bus.if_pc,          vecs[i].ipc);
      chk($sformatf("v%0d_if_inst", i),   bus.if_inst,        vecs[i].iinst);
    end

    // Reset asserted while a request is outstanding.
    @(posedge clk); #1; drive(0, '0, 1, 0, '0, 0);
    @(negedge clk); chk("wr_req_accepted", bus.imem_req_valid, 1);
    @(posedge clk); #1; drive(0, '0, 0, 0, '0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("wr_rst_req_valid", bus.imem_req_valid, 0);
    chk("wr_rst_if_valid",  bus.if_valid, 0);
    chk("wr_rst_if_pc",     bus.if_pc, 0);
    chk("wr_rst_addr",      bus.imem_req_addr, A);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_restart_valid", bus.imem_req_valid, 1);
    chk("wr_restart_addr",  bus.imem_req_addr, A);

    // Random traffic. Model: ID must see instructions in program order,
    // pc advancing by 4 per handshake and jumping to each redirect target.
    exp_pc = A; mem_busy = 0; prev_pend = 0; prev_qa = '0; idle = 0; n_hs = 0;
    mem_addr = '0; mem_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = memf(mem_addr);
          mem_busy = 0;
        end else mem_cnt--;
      end
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 9) == 0);
      bus.redirect_pc    = A + 64'({$urandom_range(0, 255), 2'b00});
      bus.if_ready       = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (bus.redirect_valid) chk("rnd_no_handshake_on_redirect", bus.if_valid, 0);
      if (bus.if_valid && bus.if_ready) begin
        chk("rnd_if_pc",   bus.if_pc, exp_pc);
        chk("rnd_if_inst", bus.if_inst, memf(exp_pc));
        exp_pc = exp_pc + 64'd4;
        n_hs++;
        idle = 0;
      end else idle++;
      if (bus.redirect_valid) exp_pc = bus.redirect_pc;
      if (prev_pend && bus.imem_req_valid) chk("rnd_addr_stable", bus.imem_req_addr, prev_qa);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("rnd_one_outstanding", mem_busy, 0);
        chk("rnd_req_addr", bus.imem_req_addr, exp_pc);
        mem_busy = 1;
        mem_addr = bus.imem_req_addr;
        mem_cnt  = $urandom_range(0, 2);
      end
      prev_pend = bus.imem_req_valid && !bus.imem_req_ready;
      prev_qa   = bus.imem_req_addr;
      if (idle > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_watchdog: no ID handshake for %0d cycles, required at most 200", idle);
        break;
      end
    end
    chk("rnd_enough_handshakes", (n_hs > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
